// File: rtl/mux_pkg.sv
// Shared constants for the 4:1 operand selector: default data width and select codes.
package mux_pkg;

  localparam int WIDTH = 3;

  localparam logic [1:0] SEL_IN0 = 2'b00;
  localparam logic [1:0] SEL_IN1 = 2'b01;
  localparam logic [1:0] SEL_IN2 = 2'b10;
  localparam logic [1:0] SEL_IN3 = 2'b11;

endpackage

// File: rtl/mux4_core.sv
// Purely combinational 4:1 selector; zero latency, no flow control.
module mux4_core
  import mux_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [W-1:0] in3,
  input  logic [1:0]   sel,
  output logic [W-1:0] out
);

  // Conditional chain instead of a case: an X/Z select propagates X rather than holding a stale value.
  assign out = (sel == SEL_IN0) ? in0 :
               (sel == SEL_IN1) ? in1 :
               (sel == SEL_IN2) ? in2 : in3;

endmodule

// File: rtl/mux_4to1_3bit.sv
// 4:1 operand selector: combinational out (0 cycles) plus registered out_q (1 cycle, sync reset to 0).
// No backpressure: captures every cycle, no enable or handshake.
module mux_4to1_3bit
  import mux_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [W-1:0] in3,
  input  logic [1:0]   sel,
  output logic [W-1:0] out,
  output logic [W-1:0] out_q
);

  logic [W-1:0] w_out;
  logic [W-1:0] r_out_q;

  mux4_core #(.W(W)) u_core (
    .in0 (in0),
    .in1 (in1),
    .in2 (in2),
    .in3 (in3),
    .sel (sel),
    .out (w_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_q <= '0;
    end else begin
      r_out_q <= w_out;
    end
  end

  assign out   = w_out;
  assign out_q = r_out_q;

endmodule

// File: tb/tb_mux_4to1_3bit.sv
// Bench for mux_4to1_3bit: directed scenarios plus randomized traffic against an array-indexed model.
module tb_mux_4to1_3bit;

  logic       clk;
  logic       rst;
  logic [2:0] in0, in1, in2, in3;
  logic [1:0] sel;
  logic [2:0] out;
  logic [2:0] out_q;

  int vectors;
  int miscompares;

  mux_4to1_3bit dut (
    .clk   (clk),
    .rst   (rst),
    .in0   (in0),
    .in1   (in1),
    .in2   (in2),
    .in3   (in3),
    .sel   (sel),
    .out   (out),
    .out_q (out_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the select value is simply an index into the list of inputs.
  function automatic logic [2:0] model_sel(input logic [1:0] s, input logic [2:0] a,
                                           input logic [2:0] b, input logic [2:0] c,
                                           input logic [2:0] d);
    logic [2:0] arr [4];
    arr[0] = a; arr[1] = b; arr[2] = c; arr[3] = d;
    return arr[s];
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; sel = 2'b01; in0 = 3'b000; in1 = 3'b110; in2 = 3'b011; in3 = 3'b101;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (out_q !== 3'b000) begin
        miscompares++;
        $display("FAIL reset_out_q edge%0d: got %b want 000", i, out_q);
      end
      vectors++;
      if (out !== 3'b110) begin
        miscompares++;
        $display("FAIL reset_out edge%0d: got %b want 110", i, out);
      end
    end
  endtask

  task automatic test_reset_release();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (out_q !== 3'b110) begin
      miscompares++;
      $display("FAIL reset_release: out_q got %b want 110", out_q);
    end
  endtask

  task automatic test_static_select();
    logic [2:0] want [4];
    want[0] = 3'b000; want[1] = 3'b110; want[2] = 3'b110; want[3] = 3'b001;
    in0 = 3'b000; in1 = 3'b110; in2 = 3'b110; in3 = 3'b001;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      vectors++;
      if (out !== want[s]) begin
        miscompares++;
        $display("FAIL static_sel%0d: out got %b want %b", s, out, want[s]);
      end
      #19;
    end
  endtask

  task automatic test_data_change();
    in2 = 3'b101; in3 = 3'b010; sel = 2'b11;
    #1;
    vectors++;
    if (out !== 3'b010) begin
      miscompares++;
      $display("FAIL data_change_sel3: out got %b want 010", out);
    end
    sel = 2'b10;
    #1;
    vectors++;
    if (out !== 3'b101) begin
      miscompares++;
      $display("FAIL data_change_sel2: out got %b want 101", out);
    end
  endtask

  task automatic test_nonselected();
    sel = 2'b00; in0 = 3'b000;
    for (int v = 0; v < 8; v++) begin
      in1 = 3'(v); in2 = 3'(v ^ 3); in3 = 3'(7 - v);
      #1;
      vectors++;
      if (out !== 3'b000) begin
        miscompares++;
        $display("FAIL nonselected v%0d: out got %b want 000", v, out);
      end
    end
  endtask

  task automatic test_latency();
    @(negedge clk);
    rst = 1'b0; sel = 2'b00; in0 = 3'b000; in3 = 3'b001;
    @(posedge clk);
    @(negedge clk);
    sel = 2'b11;
    #1;
    vectors++;
    if (out !== 3'b001) begin
      miscompares++;
      $display("FAIL latency_out: got %b want 001", out);
    end
    vectors++;
    if (out_q !== 3'b000) begin
      miscompares++;
      $display("FAIL latency_q_before: got %b want 000", out_q);
    end
    @(posedge clk); #1;
    vectors++;
    if (out_q !== 3'b001) begin
      miscompares++;
      $display("FAIL latency_q_after: got %b want 001", out_q);
    end
  endtask

  task automatic test_reset_midstream();
    logic [2:0] exp_out;
    logic [2:0] exp_q;
    in0 = 3'b001; in1 = 3'b010; in2 = 3'b100; in3 = 3'b111;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      sel = 2'(i);
      rst = (i == 4);
      exp_out = model_sel(sel, in0, in1, in2, in3);
      exp_q = rst ? 3'b000 : exp_out;
      #1;
      vectors++;
      if (out !== exp_out) begin
        miscompares++;
        $display("FAIL midstream_out cyc%0d: got %b want %b", i, out, exp_out);
      end
      @(posedge clk); #1;
      vectors++;
      if (out_q !== exp_q) begin
        miscompares++;
        $display("FAIL midstream_q cyc%0d: got %b want %b", i, out_q, exp_q);
      end
      vectors++;
      if (out !== exp_out) begin
        miscompares++;
        $display("FAIL midstream_out_post cyc%0d: got %b want %b", i, out, exp_out);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [2:0] exp_out;
    logic [2:0] exp_q;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      in0 = 3'($urandom); in1 = 3'($urandom); in2 = 3'($urandom); in3 = 3'($urandom);
      sel = 2'($urandom);
      rst = ($urandom_range(0, 9) == 0);
      exp_out = model_sel(sel, in0, in1, in2, in3);
      exp_q = rst ? 3'b000 : exp_out;
      #1;
      vectors++;
      if (out !== exp_out) begin
        miscompares++;
        $display("FAIL random_out it%0d: got %b want %b", i, out, exp_out);
      end
      @(posedge clk); #1;
      vectors++;
      if (out_q !== exp_q) begin
        miscompares++;
        $display("FAIL random_q it%0d: got %b want %b", i, out_q, exp_q);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    sel = 2'b00;
    in0 = 3'b000; in1 = 3'b000; in2 = 3'b000; in3 = 3'b000;
    test_reset();
    test_reset_release();
    test_static_select();
    test_data_change();
    test_nonselected();
    test_latency();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
